// File: rtl/pmem_arb_pkg.sv
// Shared types and widths for the I/D cacheline arbiter onto the physical-memory port.
// Grant encoding doubles as the round-robin history bit.
package pmem_arb_pkg;

   localparam int LINE_W = 256;
   localparam int ADDR_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      SERVE_I,
      SERVE_D,
      COOLDOWN
   } arb_state_t;

   typedef enum logic {
      GRANT_I,
      GRANT_D
   } grant_t;

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter: +1 on each cycle inc is high, wraps modulo 2^CNT_W.
// Cleared by synchronous rst; value is registered, visible the cycle after the event.
module perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (inc) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/pmem_arbiter.sv
// Two-client (I-cache, D-cache) arbiter onto one cacheline memory port; one transaction in flight.
// Request is latched at grant, memory strobes follow the latched copy, response returns with zero added latency.
module pmem_arbiter
   import pmem_arb_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              i_pmem_read,
   input  logic [ADDR_W-1:0] i_pmem_address,
   output logic [LINE_W-1:0] i_pmem_rdata,
   output logic              i_pmem_resp,

   input  logic              d_pmem_read,
   input  logic              d_pmem_write,
   input  logic [ADDR_W-1:0] d_pmem_address,
   input  logic [LINE_W-1:0] d_pmem_wdata,
   output logic [LINE_W-1:0] d_pmem_rdata,
   output logic              d_pmem_resp,

   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp,

   output logic [CNT_W-1:0]  i_grant_count,
   output logic [CNT_W-1:0]  d_grant_count,
   output logic [CNT_W-1:0]  conflict_count
);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   grant_t            r_last_grant;
   logic              r_write;
   logic [ADDR_W-1:0] r_addr;
   logic [LINE_W-1:0] r_wdata;

   logic w_i_req;
   logic w_d_req;
   logic w_grant_i;
   logic w_grant_d;
   logic w_conflict;
   logic w_serving;
   logic w_i_done;
   logic w_d_done;

   assign w_i_req = i_pmem_read;
   assign w_d_req = d_pmem_read | d_pmem_write;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Ties go to whichever client was not served most recently.
   always_comb begin
      w_state_nxt = r_state;
      w_grant_i   = 1'b0;
      w_grant_d   = 1'b0;
      w_conflict  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_i_req && w_d_req) begin
               w_conflict = 1'b1;
               if (r_last_grant == GRANT_I) begin
                  w_grant_d = 1'b1;
               end else begin
                  w_grant_i = 1'b1;
               end
            end else if (w_i_req) begin
               w_grant_i = 1'b1;
            end else if (w_d_req) begin
               w_grant_d = 1'b1;
            end
            if (w_grant_i) begin
               w_state_nxt = SERVE_I;
            end else if (w_grant_d) begin
               w_state_nxt = SERVE_D;
            end
         end
         SERVE_I: begin
            if (mem_resp) w_state_nxt = COOLDOWN;
         end
         SERVE_D: begin
            if (mem_resp) w_state_nxt = COOLDOWN;
         end
         COOLDOWN: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // A D-side read+write collision is treated as a write-back.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr  <= '0;
         r_write <= 1'b0;
         r_wdata <= '0;
      end else if (w_grant_i) begin
         r_addr  <= i_pmem_address;
         r_write <= 1'b0;
         r_wdata <= '0;
      end else if (w_grant_d) begin
         r_addr  <= d_pmem_address;
         r_write <= d_pmem_write;
         r_wdata <= d_pmem_wdata;
      end
   end

   assign w_i_done = (r_state == SERVE_I) && mem_resp;
   assign w_d_done = (r_state == SERVE_D) && mem_resp;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= GRANT_I;
      end else if (w_i_done) begin
         r_last_grant <= GRANT_I;
      end else if (w_d_done) begin
         r_last_grant <= GRANT_D;
      end
   end

   assign w_serving   = (r_state == SERVE_I) || (r_state == SERVE_D);
   assign mem_read    = w_serving && !r_write;
   assign mem_write   = w_serving && r_write;
   assign mem_address = r_addr;
   assign mem_wdata   = r_wdata;

   assign i_pmem_resp  = w_i_done;
   assign d_pmem_resp  = w_d_done;
   assign i_pmem_rdata = mem_rdata;
   assign d_pmem_rdata = mem_rdata;

   perf_counter #(.CNT_W(CNT_W)) u_i_grant_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (w_i_done),
      .o_count (i_grant_count)
   );

   perf_counter #(.CNT_W(CNT_W)) u_d_grant_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (w_d_done),
      .o_count (d_grant_count)
   );

   perf_counter #(.CNT_W(CNT_W)) u_conflict_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (w_conflict),
      .o_count (conflict_count)
   );

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter: expected client/data pushed at request time, popped on client resp.
module tb_pmem_arbiter;
   import pmem_arb_pkg::*;

   localparam int CNT_W = 32;

   logic              clk;
   logic              rst;
   logic              i_pmem_read;
   logic [ADDR_W-1:0] i_pmem_address;
   logic [LINE_W-1:0] i_pmem_rdata;
   logic              i_pmem_resp;
   logic              d_pmem_read;
   logic              d_pmem_write;
   logic [ADDR_W-1:0] d_pmem_address;
   logic [LINE_W-1:0] d_pmem_wdata;
   logic [LINE_W-1:0] d_pmem_rdata;
   logic              d_pmem_resp;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_address;
   logic [LINE_W-1:0] mem_wdata;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_resp;
   logic [CNT_W-1:0]  i_grant_count;
   logic [CNT_W-1:0]  d_grant_count;
   logic [CNT_W-1:0]  conflict_count;

   pmem_arbiter #(.CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_pmem_read    (i_pmem_read),
      .i_pmem_address (i_pmem_address),
      .i_pmem_rdata   (i_pmem_rdata),
      .i_pmem_resp    (i_pmem_resp),
      .d_pmem_read    (d_pmem_read),
      .d_pmem_write   (d_pmem_write),
      .d_pmem_address (d_pmem_address),
      .d_pmem_wdata   (d_pmem_wdata),
      .d_pmem_rdata   (d_pmem_rdata),
      .d_pmem_resp    (d_pmem_resp),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_address    (mem_address),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .mem_resp       (mem_resp),
      .i_grant_count  (i_grant_count),
      .d_grant_count  (d_grant_count),
      .conflict_count (conflict_count)
   );

   typedef struct packed {
      logic              is_d;
      logic [LINE_W-1:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t sb_e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_resp   = 0;
   int   n_pushed = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic is_d, input logic [LINE_W-1:0] data);
      sb.push_back({is_d, data});
      n_pushed++;
   endtask

   // Returns the number of negedges until the memory strobe is seen.
   task automatic wait_mem(input string tag, output int n);
      n = 0;
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         if (mem_read || mem_write) begin
            n = k;
            return;
         end
      end
      chk(tag, {mem_read, mem_write}, 2'b01);
   endtask

   task automatic do_resp(input logic [LINE_W-1:0] data);
      @(posedge clk); #1;
      mem_rdata = data;
      mem_resp  = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      mem_resp  = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && (i_pmem_resp || d_pmem_resp)) begin
         n_resp++;
         if (sb.size() == 0) begin
            chk("sb_unexpected_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
         end else begin
            sb_e = sb.pop_front();
            chk("sb_client_d", d_pmem_resp, sb_e.is_d);
            chk("sb_client_i", i_pmem_resp, !sb_e.is_d);
            chk("sb_data", sb_e.is_d ? d_pmem_rdata : i_pmem_rdata, sb_e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int                n;
      int                gap;
      logic [LINE_W-1:0] a5;
      logic [LINE_W-1:0] w1;
      logic [LINE_W-1:0] v;

      a5 = {32{8'hA5}};
      w1 = {8{32'h1234_5678}};
      rst = 1'b1;
      i_pmem_read = 1'b0; i_pmem_address = '0;
      d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
      mem_rdata = '0; mem_resp = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_read", mem_read, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_mem_address", mem_address, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_counters", {i_grant_count, d_grant_count, conflict_count}, 0);
      @(posedge clk); #1 rst = 1'b0;

      // I-cache read alone
      @(posedge clk); #1;
      i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1000;
      push_exp(1'b0, a5);
      wait_mem("t1_timeout", n);
      chk("t1_latency", n, 2);
      chk("t1_strobes", {mem_read, mem_write}, 2'b10);
      chk("t1_address", mem_address, 32'h0000_1000);
      repeat (4) @(posedge clk);
      do_resp(a5);
      i_pmem_read = 1'b0;
      @(negedge clk);
      chk("t1_cooldown_read", mem_read, 0);
      chk("t1_i_grant", i_grant_count, 1);
      chk("t1_d_grant", d_grant_count, 0);

      // D write-back; source data changes mid-transaction
      @(posedge clk); #1;
      d_pmem_write = 1'b1; d_pmem_address = 32'h8000_0040; d_pmem_wdata = w1;
      push_exp(1'b1, {8{32'hDEAD_BEEF}});
      wait_mem("t2_timeout", n);
      chk("t2_strobes", {mem_read, mem_write}, 2'b01);
      chk("t2_address", mem_address, 32'h8000_0040);
      chk("t2_wdata", mem_wdata, w1);
      @(posedge clk); #1;
      d_pmem_wdata = ~w1; d_pmem_address = 32'h8000_0080;
      @(negedge clk);
      chk("t2_wdata_held", mem_wdata, w1);
      chk("t2_address_held", mem_address, 32'h8000_0040);
      do_resp({8{32'hDEAD_BEEF}});
      d_pmem_write = 1'b0;
      @(negedge clk);
      chk("t2_d_grant", d_grant_count, 1);
      chk("t2_write_drop", mem_write, 0);

      // Ties from reset: D, then I (D re-asserted), then D
      do_reset();
      i_pmem_read = 1'b1; i_pmem_address = 32'h0000_2000;
      d_pmem_read = 1'b1; d_pmem_address = 32'h0000_3000;
      push_exp(1'b1, {16{16'h1111}});
      push_exp(1'b0, {16{16'h2222}});
      push_exp(1'b1, {16{16'h3333}});
      wait_mem("t3_timeout_a", n);
      chk("t3_first_addr", mem_address, 32'h0000_3000);
      chk("t3_conflict_1", conflict_count, 1);
      do_resp({16{16'h1111}});
      d_pmem_address = 32'h0000_3040;
      @(negedge clk);
      chk("t3_cooldown_conflict", conflict_count, 1);
      wait_mem("t3_timeout_b", n);
      chk("t3_second_addr", mem_address, 32'h0000_2000);
      chk("t3_conflict_2", conflict_count, 2);
      do_resp({16{16'h2222}});
      i_pmem_read = 1'b0;
      wait_mem("t3_timeout_c", n);
      chk("t3_third_addr", mem_address, 32'h0000_3040);
      chk("t3_conflict_hold", conflict_count, 2);
      do_resp({16{16'h3333}});
      d_pmem_read = 1'b0;
      @(negedge clk);
      chk("t3_grants", {i_grant_count, d_grant_count}, {32'd1, 32'd2});

      // Back-to-back D reads, held level
      @(posedge clk); #1;
      d_pmem_read = 1'b1; d_pmem_address = 32'h0000_4000;
      wait_mem("t4_timeout", n);
      for (int r = 0; r < 3; r++) begin
         v = {8{32'(32'hB0B0_0000 + r)}};
         push_exp(1'b1, v);
         chk("t4_strobes", {mem_read, mem_write}, 2'b10);
         do_resp(v);
         if (r == 2) begin
            d_pmem_read = 1'b0;
         end else begin
            gap = 0;
            for (int k = 0; k < 8; k++) begin
               @(negedge clk);
               if (mem_read) break;
               gap++;
            end
            chk("t4_gap", gap, 2);
         end
      end
      @(negedge clk);
      chk("t4_d_grant", d_grant_count, 5);
      chk("t4_i_grant", i_grant_count, 1);

      // Reset while serving I
      @(posedge clk); #1;
      i_pmem_read = 1'b1; i_pmem_address = 32'h0000_5000;
      wait_mem("t5_timeout", n);
      chk("t5_read_before", mem_read, 1);
      @(posedge clk); #1;
      rst = 1'b1; i_pmem_read = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("t5_read_after", mem_read, 0);
      chk("t5_i_resp", i_pmem_resp, 0);
      chk("t5_counters", {i_grant_count, d_grant_count, conflict_count}, 0);
      chk("t5_address", mem_address, 0);
      @(posedge clk); #1 rst = 1'b0;

      // Spurious mem_resp in IDLE
      @(posedge clk); #1;
      mem_rdata = {8{32'hFFFF_0000}}; mem_resp = 1'b1;
      @(negedge clk);
      chk("t6_no_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
      @(posedge clk); #1 mem_resp = 1'b0;
      @(negedge clk);
      chk("t6_counters", {i_grant_count, d_grant_count, conflict_count}, 0);
      chk("t6_idle", {mem_read, mem_write}, 2'b00);

      // D read and write together: write wins
      @(posedge clk); #1;
      d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 32'h0000_6000; d_pmem_wdata = ~w1;
      push_exp(1'b1, {8{32'h0C0C_0C0C}});
      wait_mem("t7_timeout", n);
      chk("t7_strobes", {mem_read, mem_write}, 2'b01);
      chk("t7_wdata", mem_wdata, ~w1);
      do_resp({8{32'h0C0C_0C0C}});
      d_pmem_read = 1'b0; d_pmem_write = 1'b0;
      @(negedge clk);
      chk("t7_d_grant", d_grant_count, 1);

      repeat (3) @(negedge clk);
      chk("sb_drain", sb.size(), 0);
      chk("resp_total", n_resp, n_pushed);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
